// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-latency fetch port for a single-cycle core,
// a word-serial loader port, and a small IDLE/LOAD/RUN/FAULT control FSM.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ip_instr_addr_from_proc,
  output logic [31:0]      op_instr_to_proc,
  output logic             op_instr_valid,
  input  logic             ip_load_start,
  input  logic             ip_load_en,
  input  logic [31:0]      ip_load_data,
  input  logic             ip_load_done,
  output logic             op_ready,
  output logic             op_fault,
  output logic [IDX_W:0]   op_load_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FAULT
  } state_e;

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH_WORDS);
  localparam logic [IDX_W:0] ONE_COUNT  = (IDX_W+1)'(1);
  localparam logic [31:0]    NOP_INSTR  = 32'h0000_0013;

  logic [31:0]      mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  logic             wr_en;
  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] fetch_idx;
  logic             aligned;
  logic             in_range;
  logic             unused_addr_hi;

  // The write pointer always equals the count below saturation, so it is
  // taken from the count instead of being a separate register.
  assign wptr      = count_q[IDX_W-1:0];
  assign fetch_idx = ip_instr_addr_from_proc[IDX_W+1:2];
  assign aligned   = (ip_instr_addr_from_proc[1:0] == 2'b00);
  assign in_range  = ({1'b0, fetch_idx} < count_q);

  // Upper address bits are deliberately dropped so fetches wrap around.
  assign unused_addr_hi = ^ip_instr_addr_from_proc[31:IDX_W+2];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ip_load_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (ip_load_start) begin
          count_d = '0;
        end else if (ip_load_en && (count_q != FULL_COUNT)) begin
          wr_en   = 1'b1;
          count_d = count_q + ONE_COUNT;
        end
        if (ip_load_done) begin
          state_d = (count_d != '0) ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        if (ip_load_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end else if (!aligned) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (ip_load_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
    ready_d = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: the array is intentionally left out of reset; the count gates every
  // read, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= ip_load_data;
    end
  end

  assign op_instr_valid   = ready_q & aligned & in_range;
  assign op_instr_to_proc = op_instr_valid ? mem[fetch_idx] : NOP_INSTR;
  assign op_ready         = ready_q;
  assign op_fault         = fault_q;
  assign op_load_count    = count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed steps plus randomized
// loads/fetches, compared against a behavioural model of the memory and FSM.
module tb_imem_responder;

  localparam int D     = 16;
  localparam int IDX_W = $clog2(D);

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    addr;
  logic [31:0]    instr;
  logic           valid;
  logic           load_start;
  logic           load_en;
  logic [31:0]    load_data;
  logic           load_done;
  logic           ready;
  logic           fault;
  logic [IDX_W:0] load_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model: program length, mode and a plain word array.
  int          m_mode;
  int          m_count;
  logic [31:0] m_mem [D];

  imem_responder #(.DEPTH_WORDS(D)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ip_instr_addr_from_proc (addr),
    .op_instr_to_proc        (instr),
    .op_instr_valid          (valid),
    .ip_load_start           (load_start),
    .ip_load_en              (load_en),
    .ip_load_data            (load_data),
    .ip_load_done            (load_done),
    .op_ready                (ready),
    .op_fault                (fault),
    .op_load_count           (load_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_count = 0;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    if (!rst) return;
    case (m_mode)
      M_IDLE: if (load_start) begin m_mode = M_LOAD; m_count = 0; end
      M_LOAD: begin
        if (load_start) m_count = 0;
        else if (load_en && m_count < D) begin
          m_mem[m_count] = load_data;
          m_count++;
        end
        if (load_done) m_mode = (m_count > 0) ? M_RUN : M_IDLE;
      end
      M_RUN: begin
        if (load_start) begin m_mode = M_LOAD; m_count = 0; end
        else if (addr % 4 != 0) m_mode = M_FAULT;
      end
      default: if (load_start) begin m_mode = M_LOAD; m_count = 0; end
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic check_all(input string tag);
    int          idx;
    logic        exp_valid;
    logic [31:0] exp_instr;
    idx       = int'((addr / 4) % D);
    exp_valid = (m_mode == M_RUN) && (addr % 4 == 0) && (idx < m_count);
    exp_instr = exp_valid ? m_mem[idx] : 32'h0000_0013;
    check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    check({tag, ".instr"}, instr, exp_instr);
    check({tag, ".ready"}, 32'(ready), 32'(m_mode == M_RUN));
    check({tag, ".fault"}, 32'(fault), 32'(m_mode == M_FAULT));
    check({tag, ".count"}, 32'(load_count), 32'(m_count));
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w, input logic with_done);
    load_en   = 1'b1;
    load_data = w;
    load_done = with_done;
    step();
    load_en   = 1'b0;
    load_done = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    addr       = 32'h0;
    load_start = 1'b0;
    load_en    = 1'b0;
    load_data  = 32'h0;
    load_done  = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    step();
    check_all("post_reset");

    // Basic three-word program.
    pulse_start();
    write_word(32'h0050_0093, 1'b0);
    write_word(32'h00A0_0113, 1'b0);
    write_word(32'h0020_81B3, 1'b0);
    check_all("loading");
    pulse_done();
    check("load3.count", 32'(load_count), 32'd3);
    check("load3.ready", 32'(ready), 32'd1);
    set_addr(32'h8);
    check("load3.addr8", instr, 32'h0020_81B3);
    check_all("load3.addr8.all");
    set_addr(32'h0);
    check_all("load3.addr0");

    // End of program: aligned but out of range is not a fault.
    set_addr(32'hC);
    check_all("eop");
    step();
    check_all("eop.next");

    // Misaligned fetch: invalid now, sticky fault afterwards.
    set_addr(32'h6);
    check_all("misal.same");
    step();
    check_all("misal.next");
    set_addr(32'h0);
    step();
    step();
    check_all("fault.hold");
    pulse_start();
    check_all("fault.restart");

    // Overfill with the final write coincident with done.
    for (int i = 0; i < D + 2; i++) begin
      write_word($urandom, (i == D + 1));
    end
    check("full.count", 32'(load_count), 32'(D));
    set_addr(32'((D - 1) * 4));
    check_all("full.last");
    set_addr(32'(D * 4));
    check_all("full.wrap");

    // Random aligned fetches over twice the depth (exercises wrap).
    for (int i = 0; i < 20; i++) begin
      set_addr(32'($urandom_range(0, 2 * D - 1) * 4));
      check_all("rand_fetch_full");
      step();
    end

    // Random-length load with random write gaps.
    set_addr(32'h0);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      load_en   = 1'($urandom_range(0, 1));
      load_data = $urandom;
      step();
    end
    load_en = 1'b0;
    pulse_done();
    check_all("rand_load.done");
    for (int i = 0; i < 20; i++) begin
      set_addr(32'($urandom_range(0, D - 1) * 4));
      check_all("rand_fetch");
      step();
    end

    // Empty load returns to IDLE; start with a write in the same cycle drops it.
    set_addr(32'h0);
    pulse_start();
    pulse_done();
    check_all("empty.idle");
    pulse_start();
    load_start = 1'b1;
    write_word(32'hDEAD_BEEF, 1'b0);
    load_start = 1'b0;
    check("start_en.count", 32'(load_count), 32'd0);
    write_word(32'h1234_5678, 1'b0);
    write_word(32'h0BAD_F00D, 1'b0);
    pulse_done();
    set_addr(32'h4);
    check_all("restart.run");

    // Asynchronous reset between edges while running.
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    rst = 1'b1;
    step();
    check_all("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the single-cycle core: answers the core's fetch address with the addressed instruction word and an instruction-valid flag in the same cycle, the way the core's fetch port requires. A separate loader port fills the memory word by word before execution. A small control FSM gates when fetches are valid, tracks the loaded program length, and latches misaligned-fetch faults.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit instruction words; power of two, at least 4.
- IDX_W, $clog2(DEPTH_WORDS): word-index width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ip_instr_addr_from_proc  in  32  byte fetch address (the core's PC).
- op_instr_to_proc  out  32  instruction word presented to the core.
- op_instr_valid  out  1  op_instr_to_proc is a loaded, in-range, aligned word.
- ip_load_start  in  1  pulse: begin or restart a program load.
- ip_load_en  in  1  write strobe: store ip_load_data at the write pointer.
- ip_load_data  in  32  program word to store.
- ip_load_done  in  1  pulse: end of load; enter RUN.
- op_ready  out  1  FSM is in RUN.
- op_fault  out  1  FSM is in FAULT (sticky misaligned fetch).
- op_load_count  out  IDX_W+1  number of words loaded, 0..DEPTH_WORDS.

## Operation
- Storage: DEPTH_WORDS x 32 register array. Synchronous write, asynchronous (combinational) read. Contents are not reset.
- Fetch index = ip_instr_addr_from_proc[IDX_W+1:2]. Bits [1:0] must be 00. Address bits above IDX_W+1 are ignored (wrap-around).
- in_range = index < op_load_count.
- FSM states are IDLE, LOAD, RUN and FAULT.
  - IDLE: ip_load_start -> LOAD. All other inputs are ignored.
  - LOAD:
    - ip_load_start clears the write pointer and count to 0; ip_load_en is ignored in that cycle.
    - Otherwise ip_load_en writes mem[wptr] and increments wptr and count.
    - When count == DEPTH_WORDS, further ip_load_en is dropped and count saturates.
    - ip_load_done -> RUN if the count after this cycle is > 0, else -> IDLE.
    - If ip_load_en and ip_load_done arrive in the same cycle, the write is stored and counted, then the transition happens.
  - RUN:
    - Fetch with bits [1:0] != 00 -> FAULT on the next edge.
    - ip_load_start -> LOAD, with pointer and count cleared. ip_load_start has priority over a fault in the same cycle.
  - FAULT: holds until ip_load_start -> LOAD.
- Output rules (combinational from state and address):
  - op_instr_valid = RUN & aligned & in_range.
  - op_instr_to_proc = mem[index] when op_instr_valid, otherwise 32'h0000_0013 (NOP, addi x0,x0,0).
  - op_ready = (state == RUN).
  - op_fault = (state == FAULT).
- An out-of-range but aligned fetch in RUN is not a fault: it returns the NOP with valid 0 (end of program).

## Timing
- Reset (rst low, asynchronous):
  - State IDLE; wptr = 0; op_load_count = 0.
  - op_instr_valid = 0; op_instr_to_proc = 32'h0000_0013; op_ready = 0; op_fault = 0.
  - Release is synchronous to clk.
- Fetch latency is zero: output follows ip_instr_addr_from_proc within the same cycle. No register sits in the read path.
- A word written at edge N is readable from cycle N onward, once in RUN.
- State changes take effect on the rising edge after the triggering input. op_ready rises in the cycle after ip_load_done is sampled.
- A misaligned fetch in cycle N drives valid = 0 in cycle N itself (alignment check is combinational), and op_fault = 1 from cycle N+1.
- Reset mid-load or mid-run returns to IDLE immediately. The memory array keeps its contents but the count is 0, so nothing is valid until a new load completes.
- Input pulses are level-sampled every edge; holding one high acts as a repeated pulse.

## Test plan
- Reset then load: release rst; pulse ip_load_start; write 3 words 0x00500093, 0x00A00113, 0x002081B3; pulse ip_load_done -> op_load_count = 3, op_ready = 1 next cycle; addr 0x8 -> instr 0x002081B3, valid 1.
- End of program: in RUN after 3 words, addr 0xC -> instr 0x00000013, valid 0, op_fault stays 0.
- Misaligned: in RUN, addr 0x6 -> valid 0 that cycle, op_fault = 1 and op_ready = 0 next cycle; the fault persists until ip_load_start, which moves the FSM to LOAD with count 0.
- Full and simultaneous events: write DEPTH_WORDS+2 words with the last ip_load_en coincident with ip_load_done -> count = DEPTH_WORDS (saturated), last word of memory = word DEPTH_WORDS-1, RUN entered; addr DEPTH_WORDS*4 wraps to index 0 and returns word 0 with valid 1.
- Empty load and restart: ip_load_start then ip_load_done with no writes -> IDLE, op_ready 0; ip_load_start and ip_load_en in the same cycle -> write ignored, count 0.
- Async reset mid-run: assert rst between clock edges while in RUN -> valid, ready and count drop to 0 immediately without waiting for a clock edge.
